// File: rtl/parity_unit.sv
// TX/RX UART parity engine: registered TX parity on frame capture, serial RX parity check.
// Optional PARITY_ERR_CNT_EN adds a saturating 8-bit parity-error counter output err_cnt.
//
// RX FSM
//   state    | meaning
//   ST_IDLE  | waiting for rx_start
//   ST_ACCUM | accumulating DATA_WIDTH data bits
//   ST_CHECK | waiting for the received parity bit
module parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic                  excep,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_bit,
  output logic                  par_rdy,
  input  logic                  rx_start,
  input  logic                  rx_bit_vld,
  input  logic                  rx_bit,
  output logic                  par_err,
  output logic                  chk_done
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  // x is the XOR-reduction of the data bits
  function automatic logic f_par(input logic en, input logic [1:0] typ, input logic x);
    logic r;
    r = 1'b0;
    if (en) begin
      unique case (typ)
        2'b00:   r = x;
        2'b01:   r = ~x;
        2'b10:   r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  // ---------------- TX path ----------------
  logic w_capture;
  logic r_par_bit;
  logic r_par_rdy;

  assign w_capture = Data_Valid && (!busy || excep);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_bit <= 1'b0;
      r_par_rdy <= 1'b0;
    end else begin
      r_par_rdy <= w_capture;
      if (w_capture) begin
        r_par_bit <= f_par(PAR_EN, PAR_TYP, ^P_DATA);
      end
    end
  end

  assign par_bit = r_par_bit;
  assign par_rdy = r_par_rdy;

  // ---------------- RX path ----------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  r_acc;
  logic                  w_acc_nxt;
  logic                  r_par_err;
  logic                  w_err_nxt;
  logic                  r_chk_done;
  logic                  w_done_nxt;
  logic                  r_cfg_en;
  logic                  w_cfg_en_nxt;
  logic [1:0]            r_cfg_typ;
  logic [1:0]            w_cfg_typ_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= 1'b0;
      r_par_err  <= 1'b0;
      r_chk_done <= 1'b0;
      r_cfg_en   <= 1'b0;
      r_cfg_typ  <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_par_err  <= w_err_nxt;
      r_chk_done <= w_done_nxt;
      r_cfg_en   <= w_cfg_en_nxt;
      r_cfg_typ  <= w_cfg_typ_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_err_nxt     = r_par_err;
    w_done_nxt    = 1'b0;
    w_cfg_en_nxt  = r_cfg_en;
    w_cfg_typ_nxt = r_cfg_typ;

    // rx_start restarts from any state and swallows a coincident data bit
    if (rx_start) begin
      w_state_nxt   = ST_ACCUM;
      w_cnt_nxt     = '0;
      w_acc_nxt     = 1'b0;
      w_err_nxt     = 1'b0;
      w_cfg_en_nxt  = PAR_EN;
      w_cfg_typ_nxt = PAR_TYP;
    end else begin
      unique case (r_state)
        ST_ACCUM: begin
          if (rx_bit_vld) begin
            w_acc_nxt = r_acc ^ rx_bit;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              if (r_cfg_en) begin
                w_state_nxt = ST_CHECK;
              end else begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b0;
              end
            end
          end
        end
        ST_CHECK: begin
          if (rx_bit_vld) begin
            w_err_nxt   = (rx_bit != f_par(1'b1, r_cfg_typ, r_acc));
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign par_err  = r_par_err;
  assign chk_done = r_chk_done;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_cnt <= 8'h00;
    end else if (r_chk_done && r_par_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_unit.sv
// Directed self-checking bench for parity_unit (DATA_WIDTH=8).
// The err_cnt checks are built only when PARITY_ERR_CNT_EN is defined.
module tb_parity_unit;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic          PAR_EN;
  logic [1:0]    PAR_TYP;
  logic          Data_Valid;
  logic          busy;
  logic          excep;
  logic [DW-1:0] P_DATA;
  logic          par_bit;
  logic          par_rdy;
  logic          rx_start;
  logic          rx_bit_vld;
  logic          rx_bit;
  logic          par_err;
  logic          chk_done;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  parity_unit #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Data_Valid (Data_Valid),
    .busy       (busy),
    .excep      (excep),
    .P_DATA     (P_DATA),
    .par_bit    (par_bit),
    .par_rdy    (par_rdy),
    .rx_start   (rx_start),
    .rx_bit_vld (rx_bit_vld),
    .rx_bit     (rx_bit),
    .par_err    (par_err),
    .chk_done   (chk_done)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tx_send(input logic en, input logic [1:0] typ, input logic [DW-1:0] d,
                         input logic bsy, input logic exc);
    PAR_EN = en; PAR_TYP = typ; P_DATA = d; busy = bsy; excep = exc; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0; busy = 1'b0; excep = 1'b0;
  endtask

  task automatic rx_go(input logic en, input logic [1:0] typ);
    PAR_EN = en; PAR_TYP = typ; rx_start = 1'b1;
    step();
    rx_start = 1'b0;
  endtask

  // sends n data bits LSB-first; no chk_done may appear before the last data bit
  task automatic rx_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      rx_bit_vld = 1'b1; rx_bit = d[i];
      step();
      rx_bit_vld = 1'b0;
      if (i < DW - 1) check("rx_no_early_done", 8'(chk_done), 8'h0);
    end
  endtask

  task automatic rx_par(input logic b);
    rx_bit_vld = 1'b1; rx_bit = b;
    step();
    rx_bit_vld = 1'b0;
  endtask

  initial begin
    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 2'b00; Data_Valid = 1'b0; busy = 1'b0;
    excep = 1'b0; P_DATA = '0; rx_start = 1'b0; rx_bit_vld = 1'b0; rx_bit = 1'b0;
    step(); step();
    RST = 1'b0;
    step();

    // reset state
    check("rst_par_bit",  8'(par_bit),  8'h0);
    check("rst_par_rdy",  8'(par_rdy),  8'h0);
    check("rst_par_err",  8'(par_err),  8'h0);
    check("rst_chk_done", 8'(chk_done), 8'h0);

    // TX modes on 8'hA7 (five ones)
    tx_send(1'b1, 2'b00, 8'hA7, 1'b0, 1'b0);
    check("tx_even_bit", 8'(par_bit), 8'h1);
    check("tx_even_rdy", 8'(par_rdy), 8'h1);
    step();
    check("tx_rdy_pulse", 8'(par_rdy), 8'h0);
    check("tx_hold", 8'(par_bit), 8'h1);
    tx_send(1'b1, 2'b01, 8'hA7, 1'b0, 1'b0);
    check("tx_odd_bit", 8'(par_bit), 8'h0);
    tx_send(1'b1, 2'b10, 8'hA7, 1'b0, 1'b0);
    check("tx_mark_bit", 8'(par_bit), 8'h1);
    tx_send(1'b1, 2'b11, 8'hA7, 1'b0, 1'b0);
    check("tx_space_bit", 8'(par_bit), 8'h0);

    // busy blocks capture, excep forces it
    tx_send(1'b1, 2'b00, 8'h01, 1'b1, 1'b0);
    check("tx_busy_bit", 8'(par_bit), 8'h0);
    check("tx_busy_rdy", 8'(par_rdy), 8'h0);
    tx_send(1'b1, 2'b00, 8'h01, 1'b1, 1'b1);
    check("tx_excep_bit", 8'(par_bit), 8'h1);
    check("tx_excep_rdy", 8'(par_rdy), 8'h1);
    tx_send(1'b0, 2'b10, 8'hA7, 1'b0, 1'b0);
    check("tx_dis_bit", 8'(par_bit), 8'h0);

    // RX even, 8'h03, correct parity
    rx_go(1'b1, 2'b00);
    rx_bits(16'h0003, 8);
    check("rx_wait_par", 8'(chk_done), 8'h0);
    rx_par(1'b0);
    check("rx_ok_done", 8'(chk_done), 8'h1);
    check("rx_ok_err",  8'(par_err),  8'h0);
    step();
    check("rx_done_pulse", 8'(chk_done), 8'h0);

    // RX even, wrong parity, error held until next rx_start
    rx_go(1'b1, 2'b00);
    rx_bits(16'h0003, 8);
    rx_par(1'b1);
    check("rx_bad_done", 8'(chk_done), 8'h1);
    check("rx_bad_err",  8'(par_err),  8'h1);
    step(); step();
    check("rx_err_held", 8'(par_err), 8'h1);
    rx_go(1'b1, 2'b00);
    check("rx_err_clr", 8'(par_err), 8'h0);

    // restart mid-frame, then full odd frame of 8'hFF
    rx_go(1'b1, 2'b01);
    rx_bits(16'h000F, 4);
    rx_go(1'b1, 2'b01);
    rx_bits(16'h00FF, 8);
    rx_par(1'b1);
    check("rx_restart_done", 8'(chk_done), 8'h1);
    check("rx_restart_err",  8'(par_err),  8'h0);

    // rx_start with a coincident bit: the bit is dropped
    PAR_EN = 1'b1; PAR_TYP = 2'b00; rx_start = 1'b1; rx_bit_vld = 1'b1; rx_bit = 1'b1;
    step();
    rx_start = 1'b0; rx_bit_vld = 1'b0;
    rx_bits(16'h0003, 8);
    check("rx_drop_wait", 8'(chk_done), 8'h0);
    rx_par(1'b0);
    check("rx_drop_done", 8'(chk_done), 8'h1);
    check("rx_drop_err",  8'(par_err),  8'h0);

    // config is latched at rx_start
    rx_go(1'b1, 2'b00);
    PAR_EN = 1'b0; PAR_TYP = 2'b01;
    rx_bits(16'h0003, 8);
    check("rx_latch_wait", 8'(chk_done), 8'h0);
    rx_par(1'b0);
    check("rx_latch_done", 8'(chk_done), 8'h1);
    check("rx_latch_err",  8'(par_err),  8'h0);

    // reset mid-frame returns the FSM to IDLE
    rx_go(1'b1, 2'b00);
    rx_bits(16'h0003, 8);
    rx_par(1'b1);
    rx_go(1'b1, 2'b00);
    rx_bits(16'h0003, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_mid_err",  8'(par_err),  8'h0);
    check("rst_mid_done", 8'(chk_done), 8'h0);
    rx_bits(16'h001F, 5);
    rx_par(1'b1);
    check("rst_mid_idle", 8'(chk_done), 8'h0);

    // parity disabled: done right after the 8th data bit
    rx_go(1'b0, 2'b00);
    rx_bits(16'h00FF, 8);
    check("rx_nopar_done", 8'(chk_done), 8'h1);
    check("rx_nopar_err",  8'(par_err),  8'h0);

    // TX and RX in the same cycle
    rx_go(1'b1, 2'b01);
    rx_bits(16'h0001, 7);
    PAR_EN = 1'b1; PAR_TYP = 2'b01; P_DATA = 8'h03; Data_Valid = 1'b1;
    rx_bit_vld = 1'b1; rx_bit = 1'b0;
    step();
    Data_Valid = 1'b0; rx_bit_vld = 1'b0;
    check("both_tx_bit", 8'(par_bit), 8'h1);
    check("both_tx_rdy", 8'(par_rdy), 8'h1);
    rx_par(1'b0);
    check("both_rx_done", 8'(chk_done), 8'h1);
    check("both_rx_err",  8'(par_err),  8'h0);

`ifdef PARITY_ERR_CNT_EN
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("cnt_rst", err_cnt, 8'h00);
    for (int k = 0; k < 300; k++) begin
      rx_go(1'b1, 2'b00);
      rx_bits(16'h0003, 8);
      rx_par(1'b1);
      step();
      if (k == 0) check("cnt_first", err_cnt, 8'h01);
    end
    check("cnt_sat", err_cnt, 8'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
